// File: rtl/k_means_controller.sv
// k_means_controller
// Top-level sequencer for the k-means core. A go pulse in IDLE starts up to
// MAX_ITER passes over num_points samples. Each pass clears the accumulators,
// reads every point, waits for the classifier pipeline to drain, then updates
// every centroid. Afterwards the K centroids are written back and interupt is
// raised until irq_ack. The block drives addresses, strobes and indices only.
//
// Optional feature: define KM_CONV_EARLY_EXIT_EN to stop at the first pass in
// which no centroid moved. Without it exactly MAX_ITER passes run and
// centroid_changed is ignored.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   go, num_points      start pulse (IDLE only) and point count latched with it
//   ram_rd_en/addr      sample RAM read strobe and address
//   class_valid         ram_rd_en delayed by one cycle
//   accum_clear         one-cycle pulse at the start of every pass
//   update_start/idx    update request for centroid update_idx
//   update_done         datapath completion of the outstanding update
//   centroid_changed    sampled with update_done
//   reg_num, reg_w_r    result register write during writeback
//   busy                high in every state except IDLE
//   iter_count          completed passes, held until the next accepted go
//   interupt, irq_ack   level interrupt in DONE and its acknowledge
//
// Update handshake: update_start is a one-cycle request that makes an update
// outstanding; the first update_done seen while it is outstanding completes
// it (centroid_changed is sampled in that same cycle). update_done with no
// update outstanding, including the request cycle itself, is ignored.
module k_means_controller #(
  parameter int ADDR_WIDTH    = 8,
  parameter int NUM_CENTROIDS = 8,
  parameter int MAX_ITER      = 16,
  parameter int CLASS_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] num_points,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  class_valid,
  output logic                  accum_clear,
  output logic                  update_start,
  output logic [3:0]            update_idx,
  input  logic                  update_done,
  input  logic                  centroid_changed,
  output logic [ADDR_WIDTH-1:0] reg_num,
  output logic                  reg_w_r,
  output logic                  busy,
  output logic [7:0]            iter_count,
  output logic                  interupt,
  input  logic                  irq_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_READ, S_DRAIN, S_UPDATE, S_CHECK, S_WRITEBACK, S_DONE
  } state_t;

  localparam int         DRAIN_W  = $clog2(CLASS_LATENCY + 2);
  localparam logic [3:0] LAST_IDX = 4'(NUM_CENTROIDS - 1);
  localparam logic [7:0] ITER_CAP = 8'(MAX_ITER);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_num_points;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DRAIN_W-1:0]    r_drain;
  logic [3:0]            r_idx;
  logic                  r_pending;
  logic [7:0]            r_iter;
  logic                  r_class_valid;
  logic [7:0]            w_iter_inc;
  logic                  w_update_ack;
  logic                  w_converged;

  assign w_iter_inc   = (r_iter == 8'hFF) ? r_iter : r_iter + 8'd1;
  assign w_update_ack = (r_state == S_UPDATE) && r_pending && update_done;

`ifdef KM_CONV_EARLY_EXIT_EN
  // OR of centroid_changed over the updates of the current pass.
  logic r_changed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_changed <= 1'b0;
    end else if (r_state == S_CLEAR) begin
      r_changed <= 1'b0;
    end else if (w_update_ack) begin
      r_changed <= r_changed | centroid_changed;
    end
  end

  assign w_converged = ~r_changed;
`else
  logic w_unused_changed;
  assign w_unused_changed = centroid_changed;
  assign w_converged      = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and strobes
  always_comb begin
    w_next       = r_state;
    ram_rd_en    = 1'b0;
    accum_clear  = 1'b0;
    update_start = 1'b0;
    reg_w_r      = 1'b0;
    busy         = 1'b1;
    interupt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (go) w_next = (num_points == '0) ? S_DONE : S_CLEAR;
      end
      S_CLEAR: begin
        accum_clear = 1'b1;
        w_next      = S_READ;
      end
      S_READ: begin
        ram_rd_en = 1'b1;
        if (r_addr == r_num_points - ADDR_WIDTH'(1)) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        // CLASS_LATENCY+1 cycles: the last point reaches the accumulator.
        if (r_drain == DRAIN_W'(CLASS_LATENCY)) w_next = S_UPDATE;
      end
      S_UPDATE: begin
        update_start = ~r_pending;
        if (w_update_ack && (r_idx == LAST_IDX)) w_next = S_CHECK;
      end
      S_CHECK: begin
        w_next = ((w_iter_inc == ITER_CAP) || w_converged) ? S_WRITEBACK : S_CLEAR;
      end
      S_WRITEBACK: begin
        reg_w_r = 1'b1;
        if (r_idx == LAST_IDX) w_next = S_DONE;
      end
      S_DONE: begin
        interupt = 1'b1;
        if (irq_ack) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Counters and latched run parameters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_num_points  <= '0;
      r_addr        <= '0;
      r_drain       <= '0;
      r_idx         <= '0;
      r_pending     <= 1'b0;
      r_iter        <= '0;
      r_class_valid <= 1'b0;
    end else begin
      r_class_valid <= (r_state == S_READ);
      r_drain       <= (r_state == S_DRAIN) ? r_drain + DRAIN_W'(1) : '0;
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_num_points <= num_points;
            r_iter       <= '0;
          end
        end
        S_CLEAR: r_addr <= '0;
        S_READ:  r_addr <= r_addr + ADDR_WIDTH'(1);
        S_CHECK: r_iter <= w_iter_inc;
        default: ;
      endcase
      // Centroid index walks 0..K-1 in UPDATE and again in WRITEBACK.
      if (r_state == S_UPDATE) begin
        if (!r_pending) begin
          r_pending <= 1'b1;
        end else if (update_done) begin
          r_pending <= 1'b0;
          r_idx     <= r_idx + 4'd1;
        end
      end else if (r_state == S_WRITEBACK) begin
        r_idx <= r_idx + 4'd1;
      end else begin
        r_idx     <= '0;
        r_pending <= 1'b0;
      end
    end
  end

  assign ram_rd_addr = (r_state == S_READ) ? r_addr : '0;
  assign update_idx  = ((r_state == S_UPDATE) || (r_state == S_WRITEBACK)) ? r_idx : 4'd0;
  assign reg_num     = (r_state == S_WRITEBACK) ? ADDR_WIDTH'(r_idx) : '0;
  assign class_valid = r_class_valid;
  assign iter_count  = r_iter;

endmodule

// File: tb/tb_k_means_controller.sv
module tb_k_means_controller;
  localparam int AW = 8;
  localparam int K  = 2;
  localparam int MI = 3;
  localparam int CL = 3;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [AW-1:0] num_points;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic          class_valid;
  logic          accum_clear;
  logic          update_start;
  logic [3:0]    update_idx;
  logic          update_done;
  logic          centroid_changed;
  logic [AW-1:0] reg_num;
  logic          reg_w_r;
  logic          busy;
  logic [7:0]    iter_count;
  logic          interupt;
  logic          irq_ack;

  initial forever #5 clk = ~clk;

  k_means_controller #(
    .ADDR_WIDTH(AW), .NUM_CENTROIDS(K), .MAX_ITER(MI), .CLASS_LATENCY(CL)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .num_points(num_points),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .class_valid(class_valid),
    .accum_clear(accum_clear), .update_start(update_start), .update_idx(update_idx),
    .update_done(update_done), .centroid_changed(centroid_changed),
    .reg_num(reg_num), .reg_w_r(reg_w_r), .busy(busy), .iter_count(iter_count),
    .interupt(interupt), .irq_ack(irq_ack)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- monitor / scoreboard capture ----------------
  bit            mon_on = 0;
  int            cyc = 0;
  int            pass_no, clr_cnt, cv_cnt, cv_err, wb_idx_err, wb_cyc;
  bit            prev_rd;
  logic [AW-1:0] rd_q[$];
  logic [3:0]    upd_q[$];
  logic [AW-1:0] wb_q[$];
  int            clr_cyc[256];
  int            wsum[256];
  bit            pass_or[256];

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_on) begin
        if (class_valid !== prev_rd) cv_err++;
        prev_rd = ram_rd_en;
        if (class_valid === 1'b1) cv_cnt++;
        if (accum_clear === 1'b1) begin
          clr_cnt++;
          if (pass_no < 255) begin
            pass_no++;
            clr_cyc[pass_no] = cyc;
            pass_or[pass_no] = 1'b0;
            wsum[pass_no]    = 0;
          end
        end
        if (ram_rd_en === 1'b1) rd_q.push_back(ram_rd_addr);
        if (update_start === 1'b1) upd_q.push_back(update_idx);
        if (reg_w_r === 1'b1) begin
          if (wb_q.size() == 0) wb_cyc = cyc;
          wb_q.push_back(reg_num);
          if (update_idx !== reg_num[3:0]) wb_idx_err++;
        end
      end
    end
  end

  // ---------------- update_done responder ----------------
  int d_fixed  = 0;   // 0: random 1..3 cycles
  int chg_mode = 0;   // 0: random changed flags, 1: changed only in pass 1
  int cd       = 0;
  bit chg_pend;

  initial begin : responder
    int d;
    update_done      = 1'b0;
    centroid_changed = 1'b0;
    forever begin
      @(negedge clk);
      update_done      = 1'b0;
      centroid_changed = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          update_done      = 1'b1;
          centroid_changed = chg_pend;
          if (mon_on && pass_no > 0) pass_or[pass_no] = pass_or[pass_no] | chg_pend;
        end
      end
      if (update_start === 1'b1 && cd == 0) begin
        d        = (d_fixed != 0) ? d_fixed : $urandom_range(1, 3);
        cd       = d;
        chg_pend = (chg_mode == 0) ? 1'($urandom_range(0, 1)) : (pass_no < 2);
        if (mon_on && pass_no > 0) wsum[pass_no] += d + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_run(input int n);
    rd_q.delete(); upd_q.delete(); wb_q.delete();
    for (int i = 0; i < 256; i++) begin
      pass_or[i] = 1'b1; wsum[i] = 0; clr_cyc[i] = 0;
    end
    pass_no = 0; clr_cnt = 0; cv_cnt = 0; cv_err = 0; prev_rd = 1'b0;
    wb_idx_err = 0; wb_cyc = 0; cd = 0;
    mon_on = 1;
    @(negedge clk);
    num_points = AW'(n);
    go         = 1'b1;
    @(negedge clk);
    go         = 1'b0;
    num_points = AW'($urandom);   // must not affect the run
  endtask

  task automatic wait_irq(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (interupt === 1'b1) ok = 1;
      else @(negedge clk);
    end
  endtask

  // Reference model: passes, address stream, update/writeback order and pass
  // length derived from the run rules and the responder's recorded waits.
  task automatic check_run(input int n, input string tag);
    logic [AW-1:0] exp_q[$];
    int exp_passes, mis, len_err, end_c;
    exp_passes = MI;
`ifdef KM_CONV_EARLY_EXIT_EN
    for (int p = 1; p <= MI; p++) begin
      if (!pass_or[p]) begin exp_passes = p; break; end
    end
`endif
    chk({tag, "_iter_count"}, iter_count, exp_passes);
    chk({tag, "_accum_clear_cnt"}, clr_cnt, exp_passes);
    for (int p = 0; p < exp_passes; p++)
      for (int a = 0; a < n; a++) exp_q.push_back(AW'(a));
    chk({tag, "_rd_count"}, rd_q.size(), exp_q.size());
    mis = 0;
    for (int i = 0; i < rd_q.size() && i < exp_q.size(); i++)
      if (rd_q[i] !== exp_q[i]) mis++;
    chk({tag, "_rd_addr_mismatches"}, mis, 0);
    chk({tag, "_class_valid_cnt"}, cv_cnt, exp_passes * n);
    chk({tag, "_class_valid_delay_err"}, cv_err, 0);
    exp_q.delete();
    for (int p = 0; p < exp_passes; p++)
      for (int c = 0; c < K; c++) exp_q.push_back(AW'(c));
    chk({tag, "_update_cnt"}, upd_q.size(), exp_q.size());
    mis = 0;
    for (int i = 0; i < upd_q.size() && i < exp_q.size(); i++)
      if (AW'(upd_q[i]) !== exp_q[i]) mis++;
    chk({tag, "_update_idx_mismatches"}, mis, 0);
    exp_q.delete();
    for (int c = 0; c < K; c++) exp_q.push_back(AW'(c));
    chk({tag, "_wb_cnt"}, wb_q.size(), K);
    mis = wb_idx_err;
    for (int i = 0; i < wb_q.size() && i < K; i++)
      if (wb_q[i] !== exp_q[i]) mis++;
    chk({tag, "_wb_reg_num_mismatches"}, mis, 0);
    len_err = 0;
    for (int p = 1; p <= clr_cnt && p < 255; p++) begin
      end_c = (p < clr_cnt) ? clr_cyc[p + 1] : wb_cyc;
      if (end_c - clr_cyc[p] != 1 + n + (CL + 1) + wsum[p] + 1) len_err++;
    end
    chk({tag, "_pass_len_err"}, len_err, 0);
    chk({tag, "_interupt"}, interupt, 1);
    chk({tag, "_busy_done"}, busy, 1);
  endtask

  // go in DONE is ignored, then irq_ack together with go returns to IDLE.
  task automatic ack_with_go(input string tag);
    int rd_before;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk({tag, "_go_in_done_irq"}, interupt, 1);
    chk({tag, "_go_in_done_busy"}, busy, 1);
    irq_ack = 1'b1;
    go      = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    go      = 1'b0;
    chk({tag, "_ack_irq_low"}, interupt, 0);
    chk({tag, "_ack_busy_low"}, busy, 0);
    rd_before = rd_q.size();
    repeat (4) @(negedge clk);
    chk({tag, "_no_restart_busy"}, busy, 0);
    chk({tag, "_no_restart_reads"}, rd_q.size(), rd_before);
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit ok;
    int n;
    rst = 1'b1; go = 1'b0; irq_ack = 1'b0; num_points = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs_a", {ram_rd_en, ram_rd_addr, class_valid, accum_clear, update_start, update_idx}, 0);
    chk("reset_outs_b", {reg_num, reg_w_r, busy, iter_count, interupt}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed run: 4 points, done 2 cycles after each start
    d_fixed = 2; chg_mode = 0;
    start_run(4);
    wait_irq(3000, ok);
    chk("runA_irq_seen", ok, 1);
    check_run(4, "runA");
    ack_with_go("runA");

    // Converges in pass 2; extra go (new num_points) during READ
    d_fixed = 0; chg_mode = 1;
    n = $urandom_range(5, 40);
    start_run(n);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (ram_rd_en === 1'b1) ok = 1;
    end
    chk("runB_reading", ok, 1);
    chk("runB_busy_read", busy, 1);
    go = 1'b1; num_points = AW'($urandom);
    @(negedge clk);
    go = 1'b0;
    wait_irq(3000, ok);
    chk("runB_irq_seen", ok, 1);
    check_run(n, "runB");
    ack_with_go("runB");

    // Zero points: straight to DONE
    chg_mode = 0;
    start_run(0);
    wait_irq(2, ok);
    chk("zero_done_fast", ok, 1);
    chk("zero_iter_count", iter_count, 0);
    chk("zero_no_reads", rd_q.size(), 0);
    chk("zero_no_clear", clr_cnt, 0);
    ack_with_go("zero");

    // Reset in the middle of READ
    start_run(20);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (ram_rd_en === 1'b1 && ram_rd_addr === AW'(5)) ok = 1;
    end
    chk("midrst_reach_addr5", ok, 1);
    rst = 1'b1;
    #1;
    chk("midrst_outs_a", {ram_rd_en, ram_rd_addr, class_valid, accum_clear, update_start, update_idx}, 0);
    chk("midrst_outs_b", {reg_num, reg_w_r, busy, iter_count, interupt}, 0);
    @(negedge clk);
    rst = 1'b0;
    start_run(6);
    wait_irq(3000, ok);
    chk("postrst_irq_seen", ok, 1);
    check_run(6, "postrst");
    ack_with_go("postrst");

    // Full address range
    start_run(255);
    wait_irq(5000, ok);
    chk("full_irq_seen", ok, 1);
    check_run(255, "full");
    chk("full_last_addr", (rd_q.size() > 0) ? rd_q[rd_q.size() - 1] : 0, 254);
    ack_with_go("full");

    // Random runs
    for (int r = 0; r < 3; r++) begin
      chg_mode = $urandom_range(0, 1);
      n = $urandom_range(1, 30);
      start_run(n);
      wait_irq(3000, ok);
      chk("rand_irq_seen", ok, 1);
      check_run(n, "rand");
      ack_with_go("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
